// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin time-multiplexed overlapping sequence detector
//
// Purpose: shares one sequence-detect next-state datapath across NCH serial
// bit streams. A round-robin arbiter grants at most one eligible channel per
// cycle. The granted channel's saved progress is advanced by one bit, and each
// full pattern match produces a registered one-cycle pulse tagged with the
// channel number.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-channel bit-valid request (held until granted)
//   in         per-channel serial data bit, valid while req is high
//   clr        per-channel synchronous progress clear (blocks the grant)
//   gnt        one-hot or zero grant, combinational
//   match_vld  registered one-cycle detection pulse
//   match_ch   channel of the detection, valid while match_vld is high
//   ovr_cnt    saturating count of detections lost to reset release
module seq_det_sched #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 5,
    parameter logic [PLEN-1:0] PATTERN = 5'b11011,
    parameter int              SW      = $clog2(PLEN + 1),
    parameter int              CW      = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] in,
    input  logic [NCH-1:0] clr,
    output logic [NCH-1:0] gnt,
    output logic           match_vld,
    output logic [CW-1:0]  match_ch,
    output logic [7:0]     ovr_cnt
);

    // Bit j of the candidate string (first s pattern bits, then b), in
    // arrival order. PATTERN[PLEN-1] is the first bit received.
    function automatic logic cand_bit(input int s, input int b, input int j);
        if (j < s) begin
            return PATTERN[PLEN-1-j];
        end
        return (b != 0);
    endfunction

    // Longest proper prefix of the pattern that is also its suffix; this is
    // where progress restarts after a full match so overlaps are detected.
    function automatic int border_len();
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < PLEN; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                if (PATTERN[k-1-m] != PATTERN[PLEN-1-m]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        return best;
    endfunction

    // Table entry {hit, next_s} for progress s and bit b. Only evaluated at
    // elaboration; the hardware sees a constant lookup table.
    function automatic logic [SW:0] step_entry(input int s, input int b);
        int   len;
        int   best;
        logic ok;
        len  = s + 1;
        best = 0;
        for (int k = 1; k <= len; k++) begin
            ok = 1'b1;
            for (int m = 0; m < k; m++) begin
                if (cand_bit(s, b, len - k + m) != PATTERN[PLEN-1-m]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = k;
            end
        end
        if (best == PLEN) begin
            return {1'b1, SW'(border_len())};
        end
        return {1'b0, SW'(best)};
    endfunction

    logic [SW:0]    nxt_tbl [PLEN][2];

    for (genvar gs = 0; gs < PLEN; gs++) begin : g_s
        for (genvar gb = 0; gb < 2; gb++) begin : g_b
            localparam logic [SW:0] ENTRY = step_entry(gs, gb);
            assign nxt_tbl[gs][gb] = ENTRY;
        end
    end

    logic [SW-1:0]  s [NCH];
    logic [CW-1:0]  ptr;
    logic           fresh_q;

    logic [NCH-1:0] eligible;
    logic [CW:0]    scan;
    logic           any_gnt;
    logic [CW-1:0]  gidx;
    logic [SW-1:0]  cur_s;
    logic           cur_b;
    logic [SW:0]    entry;
    logic           hit;
    logic [SW-1:0]  nxt_s;

    assign eligible = req & ~clr;

    // Round-robin scan starting at ptr, wrapping NCH-1 to 0. The grant is
    // forced off while reset is asserted.
    always_comb begin
        gnt     = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        scan    = '0;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                scan = {1'b0, ptr} + (CW+1)'(i);
                if (scan >= (CW+1)'(NCH)) begin
                    scan = scan - (CW+1)'(NCH);
                end
                if (!any_gnt && eligible[scan[CW-1:0]]) begin
                    any_gnt               = 1'b1;
                    gnt[scan[CW-1:0]]     = 1'b1;
                    gidx                  = scan[CW-1:0];
                end
            end
        end
    end

    // Shared next-state datapath for the granted channel.
    always_comb begin
        cur_s = s[gidx];
        cur_b = in[gidx];
        entry = '0;
        if (int'(cur_s) < PLEN) begin
            entry = nxt_tbl[cur_s][cur_b];
        end
        hit   = entry[SW];
        nxt_s = entry[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                s[i] <= '0;
            end
            ptr       <= '0;
            match_vld <= 1'b0;
            match_ch  <= '0;
            ovr_cnt   <= '0;
            fresh_q   <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    s[i] <= '0;
                end else if (gnt[i]) begin
                    s[i] <= nxt_s;
                end
            end
            if (any_gnt) begin
                ptr <= (gidx == CW'(NCH - 1)) ? '0 : gidx + CW'(1);
            end
            match_vld <= any_gnt & hit;
            if (any_gnt && hit) begin
                match_ch <= gidx;
            end
            // A completion on the first edge after reset release belongs to
            // the cycle in which reset dropped; its pulse slot was lost.
            fresh_q <= 1'b0;
            if (fresh_q && any_gnt && hit && ovr_cnt != 8'hFF) begin
                ovr_cnt <= ovr_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - self-checking bench for seq_det_sched
module tb_seq_det_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] clr;
    logic [3:0] gnt;
    logic       match_vld;
    logic [1:0] match_ch;
    logic [7:0] ovr_cnt;

    seq_det_sched #(
        .NCH    (4),
        .PLEN   (5),
        .PATTERN(5'b11011)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in       (din),
        .clr      (clr),
        .gnt      (gnt),
        .match_vld(match_vld),
        .match_ch (match_ch),
        .ovr_cnt  (ovr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] ch;
    } vec_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c,
                                input logic [3:0] g, input logic v, input logic [1:0] ch);
        vec_t e;
        e.req = r; e.din = d; e.clr = c; e.gnt = g; e.vld = v; e.ch = ch;
        vt.push_back(e);
    endfunction

    // Called at posedge+1: drive, check the combinational grant, queue the
    // expected pulse, then compare it one edge later.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c,
                        input logic [3:0] eg, input logic ev, input logic [1:0] ec,
                        input string nm);
        exp_t e;
        req = r; din = d; clr = c;
        #1;
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        e.vld = ev; e.ch = ec;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({nm, " vld"}, 32'(match_vld), 32'(e.vld));
        if (e.vld) begin
            chk({nm, " ch"}, 32'(match_ch), 32'(e.ch));
        end
    endtask

    initial begin
        logic [7:0] single_bits;
        logic [4:0] seq1;
        logic [4:0] seq3;
        logic [3:0] bits4;
        logic [3:0] r;
        logic [3:0] d;
        int         k;

        single_bits = 8'b11011011;   // bit 7 sent first
        seq1        = 5'b11011;      // channel 1 stream, MSB first
        seq3        = 5'b10110;      // channel 3 stream, MSB first

        // Fairness: all channels request, in=1 everywhere, two grants each.
        for (int c = 0; c < 8; c++) begin
            add(4'b1111, 4'b1111, 4'b0000, 4'(1 << (c % 4)), 1'b0, 2'd0);
        end
        // Clear all progress, nobody requesting.
        add(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0);
        // Single channel 0: 1,1,0,1,1,0,1,1 -> pulses after 5th and 8th bits.
        for (int c = 0; c < 8; c++) begin
            add(4'b0001, {3'b000, single_bits[7-c]}, 4'b0000, 4'b0001,
                (c == 4) || (c == 7), 2'd0);
        end
        // Idle.
        for (int c = 0; c < 10; c++) begin
            add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        end
        // Interleaved: pointer sits at 1, so grants alternate ch1, ch3.
        for (int c = 0; c < 10; c++) begin
            k = c / 2;
            r = (c == 9) ? 4'b1000 : 4'b1010;
            d = 4'b0000;
            d[3] = seq3[4-k];
            if (c % 2 == 0) begin
                d[1] = seq1[4-k];
            end else if (k < 4) begin
                d[1] = seq1[3-k];
            end
            add(r, d, 4'b0000, (c % 2 == 0) ? 4'b0010 : 4'b1000, c == 8, 2'd1);
        end
        // Channel 3 left at "110": 1,1 completes the pattern.
        add(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'd0);
        add(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3);
        // Clear priority on channel 2 after 1101.
        bits4 = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            add(4'b0100, {1'b0, bits4[3-c], 2'b00}, 4'b0000, 4'b0100, 1'b0, 2'd0);
        end
        add(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0);
        add(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0);
        bits4 = 4'b1011;
        for (int c = 0; c < 4; c++) begin
            add(4'b0100, {1'b0, bits4[3-c], 2'b00}, 4'b0000, 4'b0100, c == 3, 2'd2);
        end
        // Clear on channel 0 must not disturb the grant to channel 2.
        add(4'b0100, 4'b0000, 4'b0001, 4'b0100, 1'b0, 2'd0);

        // Reset state.
        rst = 1'b1; req = 4'b1111; din = 4'b1111; clr = 4'b0000;
        #2;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst vld", 32'(match_vld), 32'd0);
        chk("rst ch", 32'(match_ch), 32'd0);
        chk("rst ovr", 32'(ovr_cnt), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].req, vt[i].din, vt[i].clr, vt[i].gnt, vt[i].vld, vt[i].ch,
                 $sformatf("vec%0d", i));
        end

        // Async reset mid-stream: ch0 completes, then reset hits with a bit pending.
        bits4 = 4'b1101;
        for (int c = 0; c < 4; c++) begin
            step(4'b0001, {3'b000, bits4[3-c]}, 4'b0000, 4'b0001, 1'b0, 2'd0, "pre");
        end
        step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "pre_hit");
        req = 4'b0001; din = 4'b0000; clr = 4'b0000;
        #1;
        chk("pend gnt", 32'(gnt), 32'b0001);
        #1;
        rst = 1'b1;
        #1;
        chk("arst gnt", 32'(gnt), 32'd0);
        chk("arst vld", 32'(match_vld), 32'd0);
        req = 4'b0000;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post vld", 32'(match_vld), 32'd0);
        // Pointer back at 0 picks ch0 over ch1; ch0 progress restarts at 0.
        step(4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "post_ptr");
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, {3'b000, seq1[4-c]}, 4'b0000, 4'b0001, c == 4, 2'd0, "post");
        end

        chk("ovr end", 32'(ovr_cnt), 32'd0);
        chk("sb empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
